// File: rtl/sr_lsu_if.sv
// ============================================================================
// sr_lsu_if : execute-request, data-memory and writeback-response bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface sr_lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  logic        resp_valid;
  logic        resp_is_load;
  logic [4:0]  resp_rd;
  logic [31:0] resp_data;
  logic        resp_fault;
  logic [1:0]  resp_fault_code;

  // LSU side: consumes requests, masters the memory port, produces responses
  modport master (
    input  req_valid, req_store, req_funct3, req_addr, req_wdata, req_rd,
    input  mem_ack, mem_rdata,
    output req_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output resp_valid, resp_is_load, resp_rd, resp_data, resp_fault, resp_fault_code
  );

  modport slave (
    output req_valid, req_store, req_funct3, req_addr, req_wdata, req_rd,
    output mem_ack, mem_rdata,
    input  req_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  resp_valid, resp_is_load, resp_rd, resp_data, resp_fault, resp_fault_code
  );
endinterface

`default_nettype wire

// File: rtl/sr_lsu.sv
// ============================================================================
// sr_lsu : single-outstanding RV32I load/store unit with fault reporting
// Rev 1.0
// ============================================================================
`default_nettype none

module sr_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  sr_lsu_if.master   bus
);

  localparam int unsigned      CNT_W      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t r_state, w_state_nxt;

  logic             r_store;
  logic [2:0]       r_funct3;
  logic [1:0]       r_off;
  logic [29:0]      r_word;
  logic [3:0]       r_be;
  logic [31:0]      r_wdata;
  logic [4:0]       r_rd;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_data;
  logic [1:0]       r_fault_code;

  logic        w_illegal, w_misaligned;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_shift, w_load;
  logic [15:0] w_half;
  logic        w_timeout;

  // Request decode on the incoming (not yet registered) fields
  always_comb begin
    w_illegal    = 1'b1;
    w_misaligned = 1'b0;
    w_be         = 4'b1111;
    w_wdata      = bus.req_wdata;
    case (bus.req_funct3)
      3'b000, 3'b001, 3'b010: w_illegal = 1'b0;
      3'b100, 3'b101:         w_illegal = bus.req_store;
      default:                w_illegal = 1'b1;
    endcase
    case (bus.req_funct3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << bus.req_addr[1:0];
        w_wdata = {4{bus.req_wdata[7:0]}};
      end
      2'b01: begin
        w_misaligned = bus.req_addr[0];
        w_be         = bus.req_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata      = {2{bus.req_wdata[15:0]}};
      end
      default: w_misaligned = (bus.req_addr[1:0] != 2'b00);
    endcase
  end

  assign w_shift   = bus.mem_rdata >> {r_off, 3'b000};
  assign w_half    = r_off[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
  assign w_timeout = (r_cnt == C_CNT_LAST);

  always_comb begin
    w_load = bus.mem_rdata;
    case (r_funct3)
      3'b000:  w_load = {{24{w_shift[7]}}, w_shift[7:0]};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b100:  w_load = {24'd0, w_shift[7:0]};
      3'b101:  w_load = {16'd0, w_half};
      default: w_load = bus.mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.req_valid) w_state_nxt = (w_illegal || w_misaligned) ? S_RESP : S_REQ;
      S_REQ:   if (bus.mem_ack || w_timeout) w_state_nxt = S_RESP;
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_store      <= 1'b0;
      r_funct3     <= 3'd0;
      r_off        <= 2'd0;
      r_word       <= 30'd0;
      r_be         <= 4'd0;
      r_wdata      <= 32'd0;
      r_rd         <= 5'd0;
      r_cnt        <= '0;
      r_data       <= 32'd0;
      r_fault_code <= 2'd0;
    end else begin
      if (r_state == S_IDLE && bus.req_valid) begin
        r_store      <= bus.req_store;
        r_funct3     <= bus.req_funct3;
        r_off        <= bus.req_addr[1:0];
        r_word       <= bus.req_addr[31:2];
        r_be         <= w_be;
        r_wdata      <= w_wdata;
        r_rd         <= bus.req_rd;
        r_cnt        <= '0;
        r_data       <= 32'd0;
        r_fault_code <= w_illegal ? 2'd3 : (w_misaligned ? 2'd1 : 2'd0);
      end else if (r_state == S_REQ) begin
        if (bus.mem_ack) begin
          r_data <= r_store ? 32'd0 : w_load;
        end else if (w_timeout) begin
          r_fault_code <= 2'd2;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

  // Response fields are gated so they read zero outside the completion pulse
  assign bus.req_ready       = (r_state == S_IDLE);
  assign bus.mem_req         = (r_state == S_REQ);
  assign bus.mem_we          = r_store;
  assign bus.mem_addr        = {r_word, 2'b00};
  assign bus.mem_be          = r_be;
  assign bus.mem_wdata       = r_wdata;
  assign bus.resp_valid      = (r_state == S_RESP);
  assign bus.resp_is_load    = bus.resp_valid && !r_store;
  assign bus.resp_rd         = bus.resp_valid ? r_rd : 5'd0;
  assign bus.resp_fault      = bus.resp_valid && (r_fault_code != 2'd0);
  assign bus.resp_fault_code = bus.resp_valid ? r_fault_code : 2'd0;
  assign bus.resp_data       = (bus.resp_valid && r_fault_code == 2'd0) ? r_data : 32'd0;

endmodule

`default_nettype wire

// File: doc/sr_lsu.md
Name: sr_lsu

Overview:
- Load/store unit sitting directly downstream of the ALU in the execute path.
- Consumes the ALU result as the effective address (rs1 + imm) and rs2 as store data.
- Drives a single-outstanding request/acknowledge data-memory port.
- Returns aligned, sign/zero-extended load data to writeback, and reports misalignment, illegal size and bus timeout as faults.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles mem_req is held without mem_ack before the access is aborted with a fault; legal range 1..65535.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  execute stage presents a memory operation
- req_ready  out  1  LSU can accept an operation (high only in IDLE)
- req_store  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I size/sign field
- req_addr  in  32  effective address (ALU result)
- req_wdata  in  32  store data (rs2)
- req_rd  in  5  load destination register
- mem_req  out  1  memory request, held until acknowledged
- mem_we  out  1  write enable
- mem_addr  out  32  word address (bits [1:0] forced to 0)
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-replicated store data
- mem_ack  in  1  memory completes request this cycle
- mem_rdata  in  32  read data, valid when mem_ack=1
- resp_valid  out  1  one-cycle completion pulse
- resp_is_load  out  1  completed op was a load
- resp_rd  out  5  destination register of a load
- resp_data  out  32  extended load data (0 for stores and faults)
- resp_fault  out  1  op faulted; no register write allowed
- resp_fault_code  out  2  1 = misaligned, 2 = timeout, 3 = illegal funct3, 0 = none

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE.
  - All outputs 0 except req_ready=1.
  - Timeout counter 0; captured request fields 0.
- FSM states:
  - IDLE: req_ready=1. Accept on req_valid & req_ready. Accepted fields are registered.
    - Legal and aligned: next state REQ.
    - Otherwise: next state RESP with fault.
  - REQ: mem_req=1, with mem_we/mem_addr/mem_be/mem_wdata stable from registers. Counter increments each cycle without mem_ack.
    - mem_ack=1 sampled: capture extended load data; next state RESP; mem_req drops the following cycle.
    - Counter reaches TIMEOUT_CYCLES without ack: next state RESP, fault code 2, mem_req drops. A late mem_ack is ignored.
  - RESP: resp_valid=1 for exactly one cycle; next state IDLE. req_ready=0 in REQ and RESP.
- Latency: accept at cycle N, mem_req asserted at N+1. Ack sampled at N+1+k gives resp_valid at N+2+k. Minimum accept-to-response is 2 cycles; throughput is at most one op per 3 cycles.
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other value → code 3, no memory access.
- Alignment:
  - Half needs addr[0]=0; word needs addr[1:0]=00. Violation → code 1, no memory access.
  - Illegal funct3 takes priority over misalignment.
- Byte enables:
  - Byte: 1 << addr[1:0].
  - Half: 0011 if addr[1]=0, else 1100.
  - Word: 1111.
  - Loads drive the same mem_be pattern, with mem_we=0.
- Store data:
  - Byte: wdata[7:0] replicated in all 4 lanes.
  - Half: wdata[15:0] replicated in both halves.
  - Word: wdata unchanged.
- Load data: selected lane shifted to bit 0, then sign-extended (LB/LH) or zero-extended (LBU/LHU). LW passes through.
- resp_rd and resp_is_load reflect the captured request; resp_data=0 when resp_fault=1 or for stores.
- Timeout counter clears on every accept; its width is sufficient for TIMEOUT_CYCLES.
- req_valid while not ready is ignored; the upstream holds the request.
- Reset asserted mid-REQ: mem_req drops immediately (asynchronous) and no resp_valid is produced for the aborted op.

Test Plan:
- LW addr=0x100, mem_ack on first REQ cycle, rdata=0xDEADBEEF → mem_be=1111, mem_addr=0x100, resp_valid 2 cycles after accept, resp_data=0xDEADBEEF, fault=0.
- LB addr=0x103, rdata=0x80FF_FFFF → mem_be=1000, resp_data=0xFFFFFF80; same with LBU → 0x00000080.
- SH addr=0x202, wdata=0x1234ABCD, ack after 3 wait cycles → mem_we=1, mem_addr=0x200, mem_be=1100, mem_wdata=0xABCDABCD, resp_valid at accept+5, resp_is_load=0.
- LW addr=0x101 → no mem_req ever asserted, resp_valid at accept+1, fault=1, code=1; funct3=011 with addr=0x101 → code=3.
- TIMEOUT_CYCLES=4, LW with mem_ack held low → mem_req high exactly 4 cycles, then resp_fault=1, code=2; a mem_ack one cycle later produces no second response.
- rst_n pulsed low during REQ → mem_req=0 immediately, req_ready=1 after release, next LW completes normally.
